// File: rtl/mio_int_ctrl.sv
// mio_int_ctrl: prioritised interrupt controller with a three-state handshake
// (IDLE -> REQ -> SERVICE -> IDLE) towards the CPU.
// Sources are edge-detected into a pending register, masked, and the lowest
// eligible index wins. int_id is frozen from REQ entry until IDLE is reached
// again, so a later higher-priority edge never preempts an accepted request.
// Optional build macro: INT_LEVEL_EN -- level-sensitive sources. pending[k]
// follows irq_i[k] | pending[k], and an acknowledge cannot clear a line that
// is still asserted.
module mio_int_ctrl #(
  parameter int N_CH = 8,
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] irq_i,
  input  logic            Enable_i,
  output logic            Ireq,
  input  logic            Iack,
  input  logic            eoi_i,
  output logic [ID_W-1:0] int_id,
  input  logic            mask_we,
  input  logic [N_CH-1:0] mask_wdata,
  output logic [N_CH-1:0] mask_o,
  output logic [N_CH-1:0] pending_o,
  output logic            in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            ireq_next;
  logic [ID_W-1:0] id_next;
  logic [ID_W-1:0] win_id;
  logic [N_CH-1:0] pending, pending_next;
  logic [N_CH-1:0] mask;
  logic [N_CH-1:0] irq_prev;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] set_vec;
  logic [N_CH-1:0] clr_vec;

  assign eligible   = pending & ~mask;
  assign mask_o     = mask;
  assign pending_o  = pending;
  assign in_service = (state == SERVICE);

  // Priority encoder: lowest eligible index wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    win_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  // Next state, next Ireq/int_id and the acknowledge clear vector.
  always_comb begin
    state_next = state;
    ireq_next  = 1'b0;
    id_next    = int_id;
    clr_vec    = '0;
    case (state)
      IDLE: begin
        if (Enable_i && (eligible != '0)) begin
          state_next = REQ;
          ireq_next  = 1'b1;
          id_next    = win_id;
        end
      end
      REQ: begin
        // Acknowledge beats a concurrent drop of the global enable.
        if (Iack) begin
          state_next = SERVICE;
          clr_vec    = N_CH'(1) << int_id;
        end else if (!Enable_i) begin
          state_next = IDLE;
        end else begin
          ireq_next = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending update: a new set always beats the acknowledge clear.
  always_comb begin
`ifdef INT_LEVEL_EN
    set_vec = irq_i;
`else
    set_vec = irq_i & ~irq_prev;
`endif
    pending_next = (pending & ~clr_vec) | set_vec;
  end

  // State, handshake and register file update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state    <= IDLE;
      Ireq     <= 1'b0;
      int_id   <= '0;
      pending  <= '0;
      irq_prev <= '0;
      mask     <= '1;
    end else begin
      state    <= state_next;
      Ireq     <= ireq_next;
      int_id   <= id_next;
      pending  <= pending_next;
      irq_prev <= irq_i;
      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_mio_int_ctrl.sv
// tb_mio_int_ctrl: directed scenarios with literal expectations, followed by
// randomized traffic. A spec-level model runs alongside and every output is
// compared against it on each falling edge.
module tb_mio_int_ctrl;

  localparam int N_CH = 8;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] irq_i;
  logic            Enable_i;
  logic            Ireq;
  logic            Iack;
  logic            eoi_i;
  logic [ID_W-1:0] int_id;
  logic            mask_we;
  logic [N_CH-1:0] mask_wdata;
  logic [N_CH-1:0] mask_o;
  logic [N_CH-1:0] pending_o;
  logic            in_service;

  mio_int_ctrl #(.N_CH(N_CH), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_i      (irq_i),
    .Enable_i   (Enable_i),
    .Ireq       (Ireq),
    .Iack       (Iack),
    .eoi_i      (eoi_i),
    .int_id     (int_id),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_o     (mask_o),
    .pending_o  (pending_o),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0;   // waiting for an eligible source
  localparam int PH_WAIT = 1;   // request raised, waiting for Iack
  localparam int PH_SERV = 2;   // acknowledged, waiting for eoi
  int              m_phase;
  int              m_id;
  logic [N_CH-1:0] m_pend, m_mask, m_prev;
  bit              chk_en = 1'b0;

  function automatic int lowest_set(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [N_CH-1:0] elig, nxt;
    if (reset) begin
      m_phase = PH_IDLE;
      m_id    = 0;
      m_pend  = '0;
      m_prev  = '0;
      m_mask  = '1;
      chk_en  = 1'b1;
    end else begin
      elig = m_pend & ~m_mask;
      nxt  = m_pend;
      if (m_phase == PH_IDLE) begin
        if (Enable_i && elig != 0) begin
          m_phase = PH_WAIT;
          m_id    = lowest_set(elig);
        end
      end else if (m_phase == PH_WAIT) begin
        if (Iack) begin
          nxt[m_id] = 1'b0;
          m_phase   = PH_SERV;
        end else if (!Enable_i) begin
          m_phase = PH_IDLE;
        end
      end else begin
        if (eoi_i) m_phase = PH_IDLE;
      end
`ifdef INT_LEVEL_EN
      nxt = nxt | irq_i;
`else
      nxt = nxt | (irq_i & ~m_prev);
`endif
      m_pend = nxt;
      m_prev = irq_i;
      if (mask_we) m_mask = mask_wdata;
    end
  end

  // Compare process: all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_ireq",    32'(Ireq),       32'(m_phase == PH_WAIT));
      check("mdl_insvc",   32'(in_service), 32'(m_phase == PH_SERV));
      check("mdl_int_id",  32'(int_id),     32'(m_id));
      check("mdl_pending", 32'(pending_o),  32'(m_pend));
      check("mdl_mask",    32'(mask_o),     32'(m_mask));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [N_CH-1:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    step();
    mask_we    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_i = '0; Enable_i = 1'b0; Iack = 1'b0; eoi_i = 1'b0;
    mask_we = 1'b0; mask_wdata = '0;
    step(); step();
    check("rst_ireq",    32'(Ireq),       32'h0);
    check("rst_mask",    32'(mask_o),     32'hFF);
    check("rst_pending", 32'(pending_o),  32'h00);
    reset = 1'b0;

    // Single source, full handshake.
    Enable_i = 1'b1;
    write_mask(8'h00);
    irq_i = 8'h08; step();
    check("t33_pending", 32'(pending_o), 32'h08);
    check("t33_ireq_lo", 32'(Ireq),      32'h0);
    irq_i = 8'h00; step();
    check("t33_ireq",    32'(Ireq),   32'h1);
    check("t33_id",      32'(int_id), 32'h3);
    Iack = 1'b1; step(); Iack = 1'b0;
    check("t34_ireq",    32'(Ireq),       32'h0);
    check("t34_pending", 32'(pending_o),  32'h00);
    check("t34_insvc",   32'(in_service), 32'h1);
    eoi_i = 1'b1; step(); eoi_i = 1'b0;
    check("t34_eoi",     32'(in_service), 32'h0);

    // Simultaneous edges: lowest index first.
    irq_i = 8'h24; step(); irq_i = 8'h00; step();
    check("t35_id_a", 32'(int_id), 32'h2);
    Iack = 1'b1; step(); Iack = 1'b0;
    check("t35_pend", 32'(pending_o), 32'h20);
    eoi_i = 1'b1; step(); eoi_i = 1'b0;
    check("t35_idle_ireq", 32'(Ireq), 32'h0);
    step();
    check("t35_ireq_b", 32'(Ireq),   32'h1);
    check("t35_id_b",   32'(int_id), 32'h5);
    Iack = 1'b1; step(); Iack = 1'b0;
    eoi_i = 1'b1; step(); eoi_i = 1'b0;

    // Enable withdrawn while requesting, then restored.
    irq_i = 8'h02; step(); irq_i = 8'h00; step();
    check("t36_id", 32'(int_id), 32'h1);
    Enable_i = 1'b0; step();
    check("t36_ireq_off", 32'(Ireq),      32'h0);
    check("t36_pending",  32'(pending_o), 32'h02);
    Enable_i = 1'b1; step(); step();
    check("t36_ireq_on", 32'(Ireq),   32'h1);
    check("t36_id_same", 32'(int_id), 32'h1);
    Iack = 1'b1; step(); Iack = 1'b0;
    eoi_i = 1'b1; step(); eoi_i = 1'b0;

    // Masked edge still pends; unmasking makes it eligible.
    write_mask(8'h01);
    irq_i = 8'h01; step(); irq_i = 8'h00;
    check("t37_pending", 32'(pending_o), 32'h01);
    step(); step();
    check("t37_ireq_lo", 32'(Ireq), 32'h0);
    write_mask(8'h00); step();
    check("t37_ireq", 32'(Ireq),   32'h1);
    check("t37_id",   32'(int_id), 32'h0);
    Iack = 1'b1; step(); Iack = 1'b0;
    eoi_i = 1'b1; step(); eoi_i = 1'b0;

    // New edge coinciding with the acknowledge clear keeps pending set.
    irq_i = 8'h08; step(); irq_i = 8'h00; step();
    irq_i = 8'h08; Iack = 1'b1; step(); irq_i = 8'h00; Iack = 1'b0;
    check("t26_pending", 32'(pending_o),  32'h08);
    check("t26_insvc",   32'(in_service), 32'h1);

    // Reset mid-SERVICE.
    irq_i = 8'h10; step(); irq_i = 8'h00;
    check("t38_pre_pend", 32'(pending_o), 32'h18);
    reset = 1'b1; step();
    check("t38_ireq",    32'(Ireq),       32'h0);
    check("t38_id",      32'(int_id),     32'h0);
    check("t38_pending", 32'(pending_o),  32'h00);
    check("t38_mask",    32'(mask_o),     32'hFF);
    check("t38_insvc",   32'(in_service), 32'h0);

    // Line held high across reset registers one edge after release.
    irq_i = 8'h04; step();
    reset = 1'b0; step();
    check("t30_held", 32'(pending_o), 32'h04);
    step();
    check("t30_once", 32'(pending_o), 32'h04);
    irq_i = 8'h00;

    // Randomized traffic, checked by the model on every cycle.
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      irq_i      = N_CH'($urandom & $urandom & $urandom);
      Enable_i   = ($urandom_range(0, 99) < 88);
      Iack       = ($urandom_range(0, 99) < 30);
      eoi_i      = ($urandom_range(0, 99) < 25);
      mask_we    = ($urandom_range(0, 99) < 6);
      mask_wdata = N_CH'($urandom & $urandom);
      step();
    end
    reset = 1'b0; mask_we = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mio_int_ctrl.md
MIO_INT_CTRL -- requirements
Module: mio_int_ctrl

Interface
REQ-001 Parameter N_CH, default 8: number of interrupt source channels, legal range 1..32.
REQ-002 Parameter ID_W, default 3: width of the channel id, SHALL satisfy 2**ID_W >= N_CH.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_i  input  N_CH  interrupt source lines from peripherals, synchronous to clk.
REQ-006 Enable_i  input  1  CPU global interrupt enable.
REQ-007 Ireq  output  1  registered interrupt request to the CPU.
REQ-008 Iack  input  1  CPU acknowledge of Ireq, sampled on the clock edge.
REQ-009 eoi_i  input  1  single-cycle end-of-interrupt pulse from the CPU.
REQ-010 int_id  output  ID_W  registered id of the channel being requested or serviced.
REQ-011 mask_we  input  1  mask write strobe.
REQ-012 mask_wdata  input  N_CH  new mask value; bit = 1 masks the channel.
REQ-013 mask_o  output  N_CH  current mask register.
REQ-014 pending_o  output  N_CH  current pending register.
REQ-015 in_service  output  1  high while the state is SERVICE.

Function
REQ-016 A rising edge on irq_i[k] (current sample 1, previous registered sample 0) SHALL set pending[k] on the same clock edge that samples it.
REQ-017 The eligible vector SHALL be pending & ~mask; the lowest eligible index SHALL have the highest priority.
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ and SERVICE.
REQ-019 In IDLE, if Enable_i=1 and the eligible vector is non-zero, the FSM SHALL enter REQ on the next edge, load int_id with the winning index and set Ireq=1 on the same edge.
REQ-020 Ireq SHALL therefore rise one cycle after pending[k] becomes visible (two edges after the sampled irq_i edge).
REQ-021 In REQ, Iack=1 SHALL clear pending[int_id], clear Ireq and move the FSM to SERVICE on the same edge.
REQ-022 In REQ, Enable_i=0 with Iack=0 SHALL clear Ireq and return the FSM to IDLE with pending unchanged; Iack=1 SHALL take precedence over Enable_i=0.
REQ-023 int_id SHALL stay constant from REQ entry until the FSM returns to IDLE; later higher-priority edges SHALL NOT preempt it.
REQ-024 In SERVICE, eoi_i=1 SHALL return the FSM to IDLE; a new request SHALL NOT be evaluated until the cycle after returning to IDLE.
REQ-025 eoi_i outside SERVICE and Iack outside REQ SHALL be ignored.
REQ-026 When a new edge on channel k coincides with the Iack-driven clear of pending[k], set SHALL win and pending[k] SHALL remain 1.
REQ-027 mask_we=1 SHALL load mask from mask_wdata on that edge; masking the channel held in int_id SHALL NOT withdraw an active REQ.
REQ-028 Edges on masked channels SHALL still set pending; unmasking SHALL make them eligible.

Reset
REQ-029 reset=1 SHALL force: state IDLE, Ireq=0, int_id=0, pending=0, irq_prev=0, mask all-ones, in_service=0.
REQ-030 reset SHALL take priority over every other input, including mid-REQ and mid-SERVICE; an irq_i line held high across reset SHALL register one edge on the first cycle after release.

Configuration
REQ-031 Macro INT_LEVEL_EN: when defined, pending[k] SHALL equal (irq_i[k] | pending[k]) on every edge instead of setting only on edges, and Iack SHALL clear pending[k] only if irq_i[k]=0 on that edge.
REQ-032 Without INT_LEVEL_EN, operation SHALL be edge-triggered as in REQ-016 and REQ-026.

Verification
REQ-033 Reset, write mask=0x00, Enable_i=1, pulse irq_i=0x08 -> pending_o=0x08 at the next edge, then Ireq=1 and int_id=3 one edge later.
REQ-034 With Ireq=1 and int_id=3, assert Iack for 1 cycle -> Ireq=0, pending_o=0x00, in_service=1; pulse eoi_i -> in_service=0.
REQ-035 Simultaneous edges irq_i=0x24 -> int_id=2 serviced first; after eoi_i, int_id=5 requested.
REQ-036 In REQ, drop Enable_i with Iack=0 -> Ireq=0 and state IDLE; raise Enable_i again -> Ireq=1 with the same int_id.
REQ-037 Mask=0x01 and an edge on ch0 -> pending_o=0x01 and Ireq stays 0; write mask=0x00 -> Ireq=1 with int_id=0.
REQ-038 Assert reset mid-SERVICE with pending_o=0x10 -> all REQ-029 values on the next edge.
